// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default sizes for the MAC feeder
package mac_pkg;

   localparam int BITWIDTH_DEF = 32;
   localparam int LEN_W_DEF    = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PROBE = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/mac_feeder_if.sv
// rtl/mac_feeder_if.sv - job, memory, MAC and result signals of the MAC feeder
interface mac_feeder_if
   import mac_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEF,
   parameter int LEN_W    = LEN_W_DEF
) ();

   logic                  start;
   logic [LEN_W:0]        len;
   logic                  busy;
   logic                  rd_en;
   logic [LEN_W-1:0]      rd_addr;
   logic [BITWIDTH-1:0]   a_rdata;
   logic [BITWIDTH-1:0]   b_rdata;
   logic [BITWIDTH-1:0]   mac_ain;
   logic [BITWIDTH-1:0]   mac_bin;
   logic                  mac_en;
   logic [2*BITWIDTH-1:0] mac_dout;
   logic [2*BITWIDTH-1:0] res_data;
   logic                  res_valid;
   logic                  res_ready;

   // feeder side
   modport master (
      input  start, len, a_rdata, b_rdata, mac_dout, res_ready,
      output busy, rd_en, rd_addr, mac_ain, mac_bin, mac_en, res_data, res_valid
   );

   // environment side: job source, memories, MAC, result sink
   modport slave (
      output start, len, a_rdata, b_rdata, mac_dout, res_ready,
      input  busy, rd_en, rd_addr, mac_ain, mac_bin, mac_en, res_data, res_valid
   );

endinterface

// File: rtl/mac_addr_cnt.sv
// rtl/mac_addr_cnt.sv - element index counter with next-address and terminal-count flag
module mac_addr_cnt
   import mac_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [LEN_W:0]   i_len,
   output logic [LEN_W:0]   o_idx,
   output logic [LEN_W-1:0] o_next_addr,
   output logic             o_last
);

   localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};

   logic [LEN_W:0] r_idx;
   logic [LEN_W:0] w_idx_nxt;

   assign w_idx_nxt   = r_idx + ONE;
   assign o_idx       = r_idx;
   // only meaningful while not on the last element, where it is < len
   assign o_next_addr = w_idx_nxt[LEN_W-1:0];
   assign o_last      = (w_idx_nxt == i_len);

   // index of the element currently presented to the MAC
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_idx <= '0;
      end else if (i_inc) begin
         r_idx <= w_idx_nxt;
      end
   end

endmodule

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - streams A/B vectors into an external MAC and returns the job's dot product
module mac_feeder
   import mac_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEF,
   parameter int LEN_W    = LEN_W_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst,
   mac_feeder_if.master  io_bus
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LEN_W:0]        r_len;
   logic [2*BITWIDTH-1:0] r_base;
   logic [2*BITWIDTH-1:0] r_res_data;

   logic                  w_rd_en;
   logic [LEN_W-1:0]      w_rd_addr;
   logic                  w_mac_en;
   logic [BITWIDTH-1:0]   w_ain;
   logic [BITWIDTH-1:0]   w_bin;

   logic [LEN_W:0]        w_idx;
   logic [LEN_W-1:0]      w_next_addr;
   logic                  w_last;
   logic                  w_feed;

   assign w_feed = (r_state == ST_FEED);

   mac_addr_cnt #(.LEN_W(LEN_W)) u_addr_cnt (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (!w_feed),
      .i_inc       (w_feed),
      .i_len       (r_len),
      .o_idx       (w_idx),
      .o_next_addr (w_next_addr),
      .o_last      (w_last)
   );

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state and memory/MAC drive; PROBE pushes a zero product so the
   // first FEED cycle sees the pre-job MAC total on mac_dout
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_rd_addr   = '0;
      w_mac_en    = 1'b0;
      w_ain       = '0;
      w_bin       = '0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.start) begin
               w_state_nxt = (io_bus.len != '0) ? ST_PROBE : ST_DONE;
            end
         end
         ST_PROBE: begin
            w_mac_en    = 1'b1;
            w_rd_en     = 1'b1;
            w_state_nxt = ST_FEED;
         end
         ST_FEED: begin
            w_mac_en = 1'b1;
            w_ain    = io_bus.a_rdata;
            w_bin    = io_bus.b_rdata;
            if (w_last) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_rd_en   = 1'b1;
               w_rd_addr = w_next_addr;
            end
         end
         ST_DRAIN: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (io_bus.res_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // job length, MAC baseline and result; the difference is taken modulo
   // 2**(2*BITWIDTH) so a wrapping MAC total still yields the exact result
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_len      <= '0;
         r_base     <= '0;
         r_res_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (io_bus.start) begin
                  r_len <= io_bus.len;
                  if (io_bus.len == '0) begin
                     r_res_data <= '0;
                  end
               end
            end
            ST_FEED: begin
               if (w_idx == '0) begin
                  r_base <= io_bus.mac_dout;
               end
            end
            ST_DRAIN: begin
               r_res_data <= io_bus.mac_dout - r_base;
            end
            default: begin
            end
         endcase
      end
   end

   assign io_bus.busy      = (r_state != ST_IDLE);
   assign io_bus.rd_en     = w_rd_en;
   assign io_bus.rd_addr   = w_rd_addr;
   assign io_bus.mac_en    = w_mac_en;
   assign io_bus.mac_ain   = w_ain;
   assign io_bus.mac_bin   = w_bin;
   assign io_bus.res_valid = (r_state == ST_DONE);
   assign io_bus.res_data  = r_res_data;

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder with memory and MAC models
module tb_mac_feeder;
   import mac_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mac_feeder_if #(.BITWIDTH(32), .LEN_W(4)) bus32 ();
   mac_feeder_if #(.BITWIDTH(8),  .LEN_W(4)) bus8 ();

   mac_feeder #(.BITWIDTH(32), .LEN_W(4)) u_dut32 (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus32)
   );

   mac_feeder #(.BITWIDTH(8), .LEN_W(4)) u_dut8 (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus8)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // 32-bit environment: A/B memories with one-cycle read latency and a MAC
   // whose registered total is never cleared; unread cycles return garbage
   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];
   logic [31:0] a_q   = '0;
   logic [31:0] b_q   = '0;
   logic [63:0] acc32 = '0;
   int          cur_len = 0;
   int          viol = 0;
   int          mac_en_cnt = 0;

   always @(posedge clk) begin
      if (bus32.rd_en) begin
         a_q <= mem_a[bus32.rd_addr];
         b_q <= mem_b[bus32.rd_addr];
      end else begin
         a_q <= $urandom;
         b_q <= $urandom;
      end
      if (bus32.mac_en) acc32 <= acc32 + 64'(bus32.mac_ain) * 64'(bus32.mac_bin);
   end

   assign bus32.a_rdata  = a_q;
   assign bus32.b_rdata  = b_q;
   assign bus32.mac_dout = acc32;

   always @(negedge clk) begin
      if (!bus32.mac_en && (bus32.mac_ain != '0 || bus32.mac_bin != '0)) viol++;
      if (bus32.rd_en && int'(bus32.rd_addr) >= cur_len) viol++;
      if (bus32.mac_en) mac_en_cnt++;
   end

   // 8-bit environment: every element reads 0xFF, MAC total can be preloaded
   logic [7:0]  a8_q  = '0;
   logic [15:0] acc8  = '0;
   logic        pre8  = 1'b0;

   always @(posedge clk) begin
      a8_q <= bus8.rd_en ? 8'hFF : 8'h00;
      if (pre8) acc8 <= 16'hFFF0;
      else if (bus8.mac_en) acc8 <= acc8 + 16'(bus8.mac_ain) * 16'(bus8.mac_bin);
   end

   assign bus8.a_rdata  = a8_q;
   assign bus8.b_rdata  = a8_q;
   assign bus8.mac_dout = acc8;

   // one job on the 32-bit feeder; expected result is the plain dot product
   task automatic run_job(input int n, input int hold, input string tag);
      logic [63:0] exp;
      logic [63:0] held;
      int          lat;
      int          en0;
      exp = '0;
      for (int i = 0; i < n; i++) exp = exp + 64'(mem_a[i]) * 64'(mem_b[i]);
      cur_len = n;
      en0 = mac_en_cnt;
      bus32.res_ready = (hold == 0);
      bus32.start = 1'b1;
      bus32.len   = 5'(n);
      @(posedge clk); #1;
      bus32.start = 1'b0;
      lat = 1;
      while (!bus32.res_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'((n == 0) ? 1 : n + 3));
      check({tag, " result"}, bus32.res_data, exp);
      held = bus32.res_data;
      for (int h = 0; h < hold; h++) begin
         bus32.start = 1'b1;
         bus32.len   = 5'd1;
         @(posedge clk); #1;
         check({tag, " valid held"}, 64'(bus32.res_valid), 64'd1);
         check({tag, " data stable"}, bus32.res_data, held);
      end
      // start stays high through the handshake edge when stalled, and must be ignored
      bus32.start     = (hold > 0);
      bus32.res_ready = 1'b1;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      check({tag, " idle after handshake"}, 64'(bus32.busy), 64'd0);
      check({tag, " valid dropped"}, 64'(bus32.res_valid), 64'd0);
      check({tag, " mac_en cycles"}, 64'(mac_en_cnt - en0), 64'((n == 0) ? 0 : n + 1));
   endtask

   initial begin
      int lat8;
      bus32.start = 1'b0;
      bus32.len = '0;
      bus32.res_ready = 1'b1;
      bus8.start = 1'b0;
      bus8.len = '0;
      bus8.res_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy",      64'(bus32.busy),      64'd0);
      check("reset rd_en",     64'(bus32.rd_en),     64'd0);
      check("reset mac_en",    64'(bus32.mac_en),    64'd0);
      check("reset res_valid", 64'(bus32.res_valid), 64'd0);
      check("reset res_data",  bus32.res_data,       64'd0);
      rst = 1'b0;

      mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
      mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
      run_job(3, 0, "dot3");

      mem_a[0] = 2; mem_b[0] = 7;
      run_job(1, 0, "second job");

      run_job(0, 0, "len0");

      mem_a[0] = 3; mem_a[1] = 3;
      mem_b[0] = 3; mem_b[1] = 3;
      run_job(2, 5, "stalled");

      // abort in the middle of FEED
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = 32'(i + 9);
         mem_b[i] = 32'(i + 2);
      end
      cur_len = 4;
      bus32.start = 1'b1;
      bus32.len   = 5'd4;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort mac_en",    64'(bus32.mac_en),    64'd0);
      check("abort busy",      64'(bus32.busy),      64'd0);
      check("abort res_valid", 64'(bus32.res_valid), 64'd0);
      mem_a[0] = 1; mem_a[1] = 1;
      mem_b[0] = 5; mem_b[1] = 5;
      run_job(2, 0, "after abort");

      for (int j = 0; j < 10; j++) begin
         int n;
         n = $urandom_range(0, 16);
         for (int i = 0; i < 16; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
         end
         run_job(n, $urandom_range(0, 3), $sformatf("rand%0d", j));
      end

      // 8-bit feeder with the MAC total about to wrap
      pre8 = 1'b1;
      @(posedge clk); #1;
      pre8 = 1'b0;
      bus8.start = 1'b1;
      bus8.len   = 5'd1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      lat8 = 1;
      while (!bus8.res_valid && lat8 < 40) begin
         @(posedge clk); #1;
         lat8++;
      end
      check("wrap latency", 64'(lat8), 64'd4);
      check("wrap result",  64'(bus8.res_data), 64'hFE01);

      check("protocol violations", 64'(viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
